fir_coef_ctrl: RTL and testbench



---
 rtl/fir_pkg.sv | 28 ++
 rtl/coef_queue.sv | 46 ++++
 rtl/fir_coef_ctrl.sv | 112 +++++++++++
 tb/tb_fir_coef_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient path.
//   TAPS/AW/DW/QDEPTH : coefficient memory geometry and host queue depth
//   start_state_e     : start FSM encoding, also used by core-level assertions
//   popcount()        : number of set bits in a tap mask
package fir_pkg;

  localparam int unsigned TAPS   = 64;
  localparam int unsigned AW     = 6;
  localparam int unsigned DW     = 16;
  localparam int unsigned QDEPTH = 4;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StStart,
    StRun
  } start_state_e;

  function automatic logic [AW:0] popcount(input logic [TAPS-1:0] v);
    logic [AW:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(TAPS); i++) begin
      cnt = cnt + {{AW{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/coef_queue.sv
// Synchronous FIFO for pending host coefficient writes.
//   clk2, rstn : clock, synchronous active-low reset
//   flush      : drop all entries
//   push/din   : enqueue (caller guarantees !full)
//   pop/dout   : dequeue head (caller guarantees !empty); dout is the current head
//   full/empty : occupancy flags
module coef_queue #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 22
) (
  input  logic             clk2,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] din,
  input  logic             pop,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(Depth);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PW:0]      wr_ptr_q, rd_ptr_q;
  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk2) begin
    if (!rstn || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk2) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= din;
  end

  assign dout  = mem_q[rd_ptr_q[PW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

endmodule

// File: rtl/fir_coef_ctrl.sv
// Coefficient-memory controller: owns the single CMEM port, queues host writes and drains
// them only outside a filtering frame, tracks written taps, and gates the core start.
//   clk2, rstn            : clock, synchronous active-low reset
//   h_valid/h_ready       : host write handshake, h_addr/h_data the coefficient
//   clr                   : invalidate coefficients, flush queue, cancel a pending start
//   core_start_req        : start request; core_start the one-cycle start pulse
//   core_done, core_addr  : frame end pulse and tap index from the FIR core
//   mem_cen/wen/addr/d    : CMEM port (active-low enables)
//   coef_valid, wr_count  : all taps written / number of distinct taps written
module fir_coef_ctrl
  import fir_pkg::*;
(
  input  logic          clk2,
  input  logic          rstn,
  input  logic          h_valid,
  output logic          h_ready,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_data,
  input  logic          clr,
  input  logic          core_start_req,
  output logic          core_start,
  input  logic          core_done,
  input  logic [AW-1:0] core_addr,
  output logic          mem_cen,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_d,
  output logic          coef_valid,
  output logic [AW:0]   wr_count
);

  start_state_e   state_q, state_d;
  logic [TAPS-1:0] mask_q;
  logic [AW+DW-1:0] q_dout;
  logic           q_full, q_empty, q_push, q_pop;
  logic           in_frame;
  logic [AW-1:0]  head_addr;
  logic [DW-1:0]  head_data;

  assign h_ready   = !q_full && !clr && rstn;
  assign q_push    = h_valid && h_ready;
  assign in_frame  = (state_q == StStart) || (state_q == StRun);
  // A clr cycle never writes: the entry at the head is being discarded anyway.
  assign q_pop     = !in_frame && !q_empty && !clr;
  assign head_addr = q_dout[AW+DW-1:DW];
  assign head_data = q_dout[DW-1:0];

  coef_queue #(
    .Depth (QDEPTH),
    .Width (AW + DW)
  ) u_queue (
    .clk2  (clk2),
    .rstn  (rstn),
    .flush (clr),
    .push  (q_push),
    .din   ({h_addr, h_data}),
    .pop   (q_pop),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty)
  );

  // CMEM port: core reads own the port during a frame, otherwise drain the queue head.
  always_comb begin
    mem_cen  = 1'b1;
    mem_wen  = 1'b1;
    mem_addr = '0;
    mem_d    = '0;
    if (in_frame) begin
      mem_cen  = 1'b0;
      mem_addr = core_addr;
    end else if (q_pop) begin
      mem_cen  = 1'b0;
      mem_wen  = 1'b0;
      mem_addr = head_addr;
      mem_d    = head_data;
    end
  end

  always_ff @(posedge clk2) begin
    if (!rstn || clr) begin
      mask_q <= '0;
    end else if (q_pop) begin
      mask_q[head_addr] <= 1'b1;
    end
  end

  assign coef_valid = &mask_q;
  assign wr_count   = popcount(mask_q);

  always_ff @(posedge clk2) begin
    if (!rstn) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (core_start_req) state_d = StArmed;
      StArmed: begin
        if (clr)                          state_d = StIdle;
        else if (coef_valid && q_empty)   state_d = StStart;
      end
      StStart: state_d = StRun;
      StRun:   if (core_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign core_start = (state_q == StStart);

endmodule

// File: tb/tb_fir_coef_ctrl.sv
module tb_fir_coef_ctrl;
  import fir_pkg::*;

  logic          clk2, rstn, h_valid, h_ready, clr, core_start_req, core_start, core_done;
  logic [AW-1:0] h_addr, core_addr, mem_addr;
  logic [DW-1:0] h_data, mem_d;
  logic          mem_cen, mem_wen, coef_valid;
  logic [AW:0]   wr_count;

  fir_coef_ctrl dut (
    .clk2           (clk2),
    .rstn           (rstn),
    .h_valid        (h_valid),
    .h_ready        (h_ready),
    .h_addr         (h_addr),
    .h_data         (h_data),
    .clr            (clr),
    .core_start_req (core_start_req),
    .core_start     (core_start),
    .core_done      (core_done),
    .core_addr      (core_addr),
    .mem_cen        (mem_cen),
    .mem_wen        (mem_wen),
    .mem_addr       (mem_addr),
    .mem_d          (mem_d),
    .coef_valid     (coef_valid),
    .wr_count       (wr_count)
  );

  initial begin
    clk2 = 1'b0;
    forever #5 clk2 = ~clk2;
  end

  // Expected CMEM/start activity, tagged with the cycle it must appear in.
  typedef struct {
    int            cyc;
    bit            start;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } hw_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   acc_n;

  // Reference model: pending host writes, written-tap set, frame protocol flags.
  hw_t             m_q[$];
  logic [TAPS-1:0] m_mask = '0;
  bit              m_waiting = 0, m_starting = 0, m_running = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Monitor: whenever the DUT drives CMEM or pulses start, pop and compare.
  always @(negedge clk2) begin
    if (rstn) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_output cyc=%0d actual=idle required=activity_at_%0d",
                 cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (mem_cen == 1'b0 || core_start) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output cyc=%0d actual=cen%0b_wen%0b_start%0b required=idle",
                   cyc, mem_cen, mem_wen, core_start);
        end else begin
          mon_e = exp_q.pop_front();
          check("mon_cen", 32'(mem_cen), 32'(0));
          check("mon_start", 32'(core_start), 32'(mon_e.start));
          check("mon_wen", 32'(mem_wen), 32'(!mon_e.wr));
          check("mon_addr", 32'(mem_addr), 32'(mon_e.addr));
          if (mon_e.wr) check("mon_data", 32'(mem_d), 32'(mon_e.data));
        end
      end
    end
  end

  task automatic step(input bit rn, input bit hv, input logic [AW-1:0] ha,
                      input logic [DW-1:0] hd, input bit cl, input bit rq, input bit dn,
                      input logic [AW-1:0] ca, output bit acc);
    bit frame, all_set, q_empty;
    @(posedge clk2);
    #1;
    rstn = rn; h_valid = hv; h_addr = ha; h_data = hd;
    clr = cl; core_start_req = rq; core_done = dn; core_addr = ca;
    cyc++;
    frame = m_starting || m_running;
    if (rn) begin
      if (frame)
        exp_q.push_back('{cyc: cyc, start: m_starting, wr: 1'b0, addr: ca, data: '0});
      else if (!cl && m_q.size() > 0)
        exp_q.push_back('{cyc: cyc, start: 1'b0, wr: 1'b1, addr: m_q[0].a, data: m_q[0].d});
    end
    acc = rn && hv && (m_q.size() < QDEPTH) && !cl;
    @(negedge clk2);
    #1;
    check("h_ready", 32'(h_ready), 32'(rn && (m_q.size() < QDEPTH) && !cl));
    if (rn) begin
      check("wr_count", 32'(wr_count), 32'($countones(m_mask)));
      check("coef_valid", 32'(coef_valid), 32'(m_mask == '1));
    end
    if (!rn) begin
      m_q.delete();
      m_mask = '0;
      m_waiting = 0; m_starting = 0; m_running = 0;
    end else begin
      all_set = (m_mask == '1);
      q_empty = (m_q.size() == 0);
      if (m_waiting) begin
        if (cl) m_waiting = 0;
        else if (all_set && q_empty) begin m_waiting = 0; m_starting = 1; end
      end else if (m_starting) begin
        m_starting = 0; m_running = 1;
      end else if (m_running) begin
        if (dn) m_running = 0;
      end else if (rq) begin
        m_waiting = 1;
      end
      if (cl) begin
        m_q.delete();
        m_mask = '0;
      end else begin
        if (!frame && m_q.size() > 0) begin
          m_mask[m_q[0].a] = 1'b1;
          void'(m_q.pop_front());
        end
        if (acc) m_q.push_back('{a: ha, d: hd});
      end
    end
  endtask

  task automatic cyc1(input bit hv, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                      input bit cl, input bit rq, input bit dn, input logic [AW-1:0] ca);
    step(1'b1, hv, ha, hd, cl, rq, dn, ca, acc_n);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc1(0, '0, '0, 0, 0, 0, '0);
  endtask

  task automatic write_all(input bit seq_data);
    for (int i = 0; i < int'(TAPS); i++)
      cyc1(1, AW'(i), seq_data ? DW'(16'h100 + i) : DW'($urandom), 0, 0, 0, '0);
  endtask

  task automatic run_until_running();
    for (int i = 0; i < 10 && !m_running; i++) idle(1);
  endtask

  initial begin
    bit acc;
    rstn = 1'b0; h_valid = 1'b0; h_addr = '0; h_data = '0; clr = 1'b0;
    core_start_req = 1'b0; core_done = 1'b0; core_addr = '0;

    for (int i = 0; i < 2; i++) step(0, 0, '0, '0, 0, 0, 0, '0, acc);
    idle(2);

    // Full coefficient load, back-to-back writes.
    write_all(1'b1);
    idle(2);
    check("full_count", 32'(wr_count), 32'(TAPS));
    check("full_valid", 32'(coef_valid), 32'(1));

    // Frame with writes held off: fifth push must wait for core_done.
    cyc1(0, '0, '0, 0, 1, 0, '0);
    run_until_running();
    for (int k = 0; k < 4; k++) cyc1(1, AW'(k * 3), DW'($urandom), 0, 0, 0, AW'(k));
    for (int i = 0; i < int'(TAPS); i++) cyc1(1, 6'd50, 16'hbeef, 0, 0, 0, AW'(i));
    step(1, 1, 6'd50, 16'hbeef, 0, 0, 1, '0, acc);
    for (int i = 0; i < 10 && !acc; i++) step(1, 1, 6'd50, 16'hbeef, 0, 0, 0, '0, acc);
    idle(6);

    // Start withheld at 63 taps until the last one lands.
    cyc1(0, '0, '0, 1, 0, 0, '0);
    for (int i = 0; i < int'(TAPS) - 1; i++) cyc1(1, AW'(i), DW'($urandom), 0, 0, 0, '0);
    idle(1);
    cyc1(0, '0, '0, 0, 1, 0, '0);
    idle(5);
    cyc1(1, 6'd63, 16'h1234, 0, 0, 0, '0);
    idle(4);
    for (int i = 0; i < 8; i++) cyc1(0, '0, '0, 0, 0, (i == 7), AW'(i * 7));
    idle(2);

    // clr while armed with writes in flight.
    cyc1(0, '0, '0, 1, 0, 0, '0);
    cyc1(0, '0, '0, 0, 1, 0, '0);
    cyc1(1, 6'd1, 16'h0aaa, 0, 0, 0, '0);
    cyc1(1, 6'd2, 16'h0bbb, 0, 0, 0, '0);
    cyc1(1, 6'd3, 16'h0ccc, 1, 0, 0, '0);
    idle(3);
    check("clr_count", 32'(wr_count), 32'(0));

    // Reset in the middle of a drain.
    for (int k = 0; k < 4; k++) cyc1(1, AW'(10 + k), DW'($urandom), 0, 0, 0, '0);
    step(0, 0, '0, '0, 0, 0, 0, '0, acc);
    idle(3);
    check("rst_count", 32'(wr_count), 32'(0));

    // Randomised traffic on top of a complete coefficient set.
    write_all(1'b0);
    for (int i = 0; i < 1500; i++) begin
      cyc1($urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom),
           $urandom_range(0, 399) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0, AW'($urandom));
    end
    idle(4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
